// File: rtl/fpu_esc_dispatcher.sv
// fpu_esc_dispatcher: issues CPU ESC instructions to the 8087 port and returns one completion record each.
module fpu_esc_dispatcher #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int READY_GUARD    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        esc_valid,
    output logic        esc_ready,
    input  logic [7:0]  esc_opcode,
    input  logic [7:0]  esc_modrm,
    input  logic [79:0] esc_mem_data,
    input  logic [31:0] esc_int_data,
    output logic [7:0]  fpu_opcode,
    output logic [7:0]  fpu_modrm,
    output logic        fpu_execute,
    output logic [79:0] fpu_data_in,
    output logic [31:0] fpu_int_data_in,
    input  logic        fpu_ready,
    input  logic        fpu_error,
    input  logic [79:0] fpu_data_out,
    input  logic [31:0] fpu_int_data_out,
    output logic        fpu_busy,
    output logic        res_valid,
    output logic [79:0] res_data,
    output logic [31:0] res_int_data,
    output logic        res_store,
    output logic        res_error,
    output logic        res_timeout,
    output logic        res_illegal
);
    localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, GUARD = 3'd2, WAIT = 3'd3, DONE = 3'd4;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(READY_GUARD + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GRD_LAST = GW'(READY_GUARD - 1);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [GW-1:0] gcnt;
    logic          legal;
    logic          store;
    logic [2:0]    rg;

    assign legal = esc_opcode[7:3] == 5'b11011;
    assign rg = fpu_modrm[5:3];
    // classification uses the latched instruction, which is stable until DONE
    assign store = (fpu_modrm[7:6] != 2'b11) &&
                   (((fpu_opcode == 8'hD9 || fpu_opcode == 8'hDD) && (rg == 3'd2 || rg == 3'd3)) ||
                    ((fpu_opcode == 8'hDB || fpu_opcode == 8'hDF) && (rg == 3'd2 || rg == 3'd3 || rg == 3'd7)));

    assign esc_ready   = state == IDLE;
    assign fpu_execute = state == ISSUE;
    assign fpu_busy    = state != IDLE;
    assign res_valid   = state == DONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            gcnt            <= '0;
            fpu_opcode      <= '0;
            fpu_modrm       <= '0;
            fpu_data_in     <= '0;
            fpu_int_data_in <= '0;
            res_data        <= '0;
            res_int_data    <= '0;
            res_store       <= 1'b0;
            res_error       <= 1'b0;
            res_timeout     <= 1'b0;
            res_illegal     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (esc_valid) begin
                    fpu_opcode      <= esc_opcode;
                    fpu_modrm       <= esc_modrm;
                    fpu_data_in     <= esc_mem_data;
                    fpu_int_data_in <= esc_int_data;
                    if (legal) state <= ISSUE;
                    else begin
                        state        <= DONE;
                        res_illegal  <= 1'b1;
                        res_store    <= 1'b0;
                        res_error    <= 1'b0;
                        res_timeout  <= 1'b0;
                        res_data     <= '0;
                        res_int_data <= '0;
                    end
                end
                ISSUE: begin
                    state <= GUARD;
                    gcnt  <= '0;
                end
                GUARD: if (gcnt == GRD_LAST) begin
                    state <= WAIT;
                    cnt   <= '0;
                end else gcnt <= gcnt + 1'b1;
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // ready takes priority over a coincident watchdog expiry
                    if (fpu_ready) begin
                        state        <= DONE;
                        res_error    <= fpu_error;
                        res_store    <= store;
                        res_data     <= store ? fpu_data_out : '0;
                        res_int_data <= store ? fpu_int_data_out : '0;
                        res_timeout  <= 1'b0;
                        res_illegal  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state        <= DONE;
                        res_error    <= 1'b0;
                        res_store    <= store;
                        res_data     <= '0;
                        res_int_data <= '0;
                        res_timeout  <= 1'b1;
                        res_illegal  <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_esc_dispatcher.sv
// tb_fpu_esc_dispatcher: directed and randomized checks against a cycle-count reference model.
module tb_fpu_esc_dispatcher;
    localparam int T  = 16;
    localparam int RG = 1;

    logic        clk = 1'b0, reset = 1'b1;
    logic        esc_valid = 1'b0, esc_ready;
    logic [7:0]  esc_opcode = '0, esc_modrm = '0;
    logic [79:0] esc_mem_data = '0;
    logic [31:0] esc_int_data = '0;
    logic [7:0]  fpu_opcode, fpu_modrm;
    logic        fpu_execute;
    logic [79:0] fpu_data_in;
    logic [31:0] fpu_int_data_in;
    logic        fpu_ready = 1'b0, fpu_error = 1'b0;
    logic [79:0] fpu_data_out = '0;
    logic [31:0] fpu_int_data_out = '0;
    logic        fpu_busy, res_valid, res_store, res_error, res_timeout, res_illegal;
    logic [79:0] res_data;
    logic [31:0] res_int_data;

    int n_assert = 0, n_fail = 0;
    logic [79:0] e_data = '0;
    logic [31:0] e_int = '0;
    logic        e_store = 1'b0, e_err = 1'b0, e_to = 1'b0, e_ill = 1'b0;

    always #5 clk = ~clk;

    fpu_esc_dispatcher #(.TIMEOUT_CYCLES(T), .READY_GUARD(RG)) dut (
        .clk(clk), .reset(reset), .esc_valid(esc_valid), .esc_ready(esc_ready),
        .esc_opcode(esc_opcode), .esc_modrm(esc_modrm), .esc_mem_data(esc_mem_data),
        .esc_int_data(esc_int_data), .fpu_opcode(fpu_opcode), .fpu_modrm(fpu_modrm),
        .fpu_execute(fpu_execute), .fpu_data_in(fpu_data_in), .fpu_int_data_in(fpu_int_data_in),
        .fpu_ready(fpu_ready), .fpu_error(fpu_error), .fpu_data_out(fpu_data_out),
        .fpu_int_data_out(fpu_int_data_out), .fpu_busy(fpu_busy), .res_valid(res_valid),
        .res_data(res_data), .res_int_data(res_int_data), .res_store(res_store),
        .res_error(res_error), .res_timeout(res_timeout), .res_illegal(res_illegal)
    );

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] r80();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[79:0];
    endfunction

    function automatic logic is_legal(input logic [7:0] op);
        return op >= 8'hD8 && op <= 8'hDF;
    endfunction

    function automatic logic is_store(input logic [7:0] op, input logic [7:0] m);
        int r;
        r = int'(m) / 8 % 8;
        if (int'(m) >= 192) return 1'b0;
        if (op == 8'hD9 || op == 8'hDD) return r == 2 || r == 3;
        if (op == 8'hDB || op == 8'hDF) return r == 2 || r == 3 || r == 7;
        return 1'b0;
    endfunction

    // cycle (relative to acceptance) at which res_valid is expected
    function automatic int done_k(input logic [7:0] op, input int rd);
        int w0, eff;
        if (!is_legal(op)) return 1;
        w0  = 2 + RG;
        eff = rd > w0 ? rd : w0;
        return (eff - w0 < T) ? eff + 1 : w0 + T;
    endfunction

    task automatic check_fields();
        chk("res_data", res_data, e_data);
        chk("res_int_data", res_int_data, e_int);
        chk("res_store", res_store, e_store);
        chk("res_error", res_error, e_err);
        chk("res_timeout", res_timeout, e_to);
        chk("res_illegal", res_illegal, e_ill);
    endtask

    task automatic txn(input logic [7:0] op, input logic [7:0] m, input int rd, input logic err,
                       input logic [79:0] dout, input logic [31:0] iout);
        int kd;
        logic lg, st, timed;
        logic [79:0] mem;
        logic [31:0] iv;
        kd    = done_k(op, rd);
        lg    = is_legal(op);
        st    = is_store(op, m);
        timed = lg && kd == 2 + RG + T && rd >= 2 + RG + T;
        mem   = r80();
        iv    = $urandom;
        chk("esc_ready_before", esc_ready, 1'b1);
        esc_valid = 1'b1; esc_opcode = op; esc_modrm = m; esc_mem_data = mem; esc_int_data = iv;
        for (int k = 1; k <= kd + 1; k++) begin
            @(posedge clk); #1;
            esc_valid = 1'b0; esc_opcode = 8'($urandom); esc_modrm = 8'($urandom);
            esc_mem_data = r80(); esc_int_data = $urandom;
            fpu_ready        = k >= rd;
            fpu_error        = k >= rd ? err : 1'($urandom);
            fpu_data_out     = k >= rd ? dout : r80();
            fpu_int_data_out = k >= rd ? iout : $urandom;
            @(negedge clk);
            if (k == kd) begin
                e_ill   = !lg;
                e_to    = timed;
                e_store = lg && st;
                e_err   = lg && !timed && err;
                e_data  = (lg && !timed && st) ? dout : '0;
                e_int   = (lg && !timed && st) ? iout : '0;
            end
            chk("fpu_execute", fpu_execute, k == 1 && lg);
            chk("fpu_busy", fpu_busy, k <= kd);
            chk("esc_ready", esc_ready, k > kd);
            chk("res_valid", res_valid, k == kd);
            if (k <= kd) begin
                chk("fpu_opcode", fpu_opcode, op);
                chk("fpu_modrm", fpu_modrm, m);
                chk("fpu_data_in", fpu_data_in, mem);
                chk("fpu_int_data_in", fpu_int_data_in, iv);
            end
            check_fields();
        end
    endtask

    task automatic check_reset_state();
        chk("rst_esc_ready", esc_ready, 1'b1);
        chk("rst_execute", fpu_execute, 1'b0);
        chk("rst_busy", fpu_busy, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_fpu_opcode", fpu_opcode, 8'h00);
        chk("rst_fpu_modrm", fpu_modrm, 8'h00);
        chk("rst_fpu_data_in", fpu_data_in, 80'h0);
        chk("rst_fpu_int_data_in", fpu_int_data_in, 32'h0);
        e_data = '0; e_int = '0; e_store = 1'b0; e_err = 1'b0; e_to = 1'b0; e_ill = 1'b0;
        check_fields();
    endtask

    // accept an instruction, run kstop cycles with ready low, then reset asynchronously
    task automatic abort(input logic [7:0] op, input logic [7:0] m, input int kstop);
        esc_valid = 1'b1; esc_opcode = op; esc_modrm = m; esc_mem_data = r80(); esc_int_data = $urandom;
        for (int k = 1; k <= kstop; k++) begin
            @(posedge clk); #1;
            esc_valid = 1'b0; fpu_ready = 1'b0;
            @(negedge clk);
        end
        chk("pre_abort_busy", fpu_busy, 1'b1);
        chk("pre_abort_execute", fpu_execute, kstop == 1);
        #2 reset = 1'b1;
        #1 check_reset_state();
        @(negedge clk) reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_abort_res_valid", res_valid, 1'b0);
            chk("post_abort_esc_ready", esc_ready, 1'b1);
        end
    endtask

    initial begin
        logic [7:0] op;
        int rd;
        repeat (2) @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        @(negedge clk);
        txn(8'hD9, 8'hE8, 6, 1'b0, r80(), $urandom);
        txn(8'hDB, 8'h3B, 5, 1'b0, 80'h3FFF8000000000000000, 32'h1234_5678);
        txn(8'h90, 8'h00, 0, 1'b0, r80(), $urandom);
        txn(8'hD9, 8'hE8, 1000, 1'b0, r80(), $urandom);
        txn(8'hDD, 8'h10, 2 + RG + T - 1, 1'b0, 80'h4000_C90F_DAA2_2168_C235, $urandom);
        txn(8'hDF, 8'h5A, 4, 1'b1, r80(), 32'hDEAD_BEEF);
        txn(8'hD9, 8'hE0, 0, 1'b1, r80(), $urandom);
        abort(8'hD9, 8'hE8, 5);
        abort(8'hDB, 8'h3B, 1);
        txn(8'hD9, 8'hEE, 4, 1'b0, r80(), $urandom);
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 7) == 0 ? 8'($urandom) : 8'(8'hD8 + $urandom_range(0, 7));
            rd = $urandom_range(0, 7) == 0 ? 1000 : int'($urandom_range(0, 22));
            txn(op, 8'($urandom), rd, 1'($urandom), r80(), $urandom);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/fpu_esc_dispatcher.md
Name: fpu_esc_dispatcher

Overview:
CPU-side initiator for the 8087 coprocessor port. It accepts ESC instructions (opcode D8–DF plus ModR/M plus memory operand) from the CPU execution unit and drives them into the FPU as a one-cycle execute pulse. It then waits for the FPU ready handshake, captures store results (FST/FSTP/FIST) from the FPU data outputs and returns a single completion record to the CPU. It also provides the busy indication used by WAIT/FWAIT and a watchdog timeout for a hung FPU.

Parameters:
TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT before aborting with res_timeout.
READY_GUARD, 1, cycles after the execute pulse during which fpu_ready is ignored (the FPU may still show ready from idle); must be ≥1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
esc_valid  in  1  CPU presents an ESC instruction
esc_ready  out  1  dispatcher can accept (IDLE only)
esc_opcode  in  8  instruction opcode byte
esc_modrm  in  8  ModR/M byte
esc_mem_data  in  80  memory operand, 80-bit extended format (FLD m80 etc.)
esc_int_data  in  32  integer memory operand
fpu_opcode  out  8  to FPU cpu_opcode
fpu_modrm  out  8  to FPU cpu_modrm
fpu_execute  out  1  one-cycle execute strobe
fpu_data_in  out  80  to FPU cpu_data_in
fpu_int_data_in  out  32  to FPU cpu_int_data_in
fpu_ready  in  1  FPU ready
fpu_error  in  1  FPU error, sampled with ready
fpu_data_out  in  80  FPU store data
fpu_int_data_out  in  32  FPU integer store data
fpu_busy  out  1  high whenever state != IDLE (drives WAIT/FWAIT stall)
res_valid  out  1  one-cycle completion pulse
res_data  out  80  captured fpu_data_out (stores only, else 0)
res_int_data  out  32  captured fpu_int_data_out (stores only, else 0)
res_store  out  1  instruction classified as store
res_error  out  1  fpu_error at completion
res_timeout  out  1  watchdog abort
res_illegal  out  1  opcode[7:3] != 5'b11011

Behaviour:
- Reset (async): state=IDLE; all outputs 0 except esc_ready=1. The counter and latched operands clear. A reset mid-operation drops fpu_execute immediately; no res_valid is generated for the aborted instruction.
- States: IDLE, ISSUE, GUARD, WAIT, DONE.
- IDLE: esc_ready=1. When esc_valid is high at cycle N, opcode, modrm and both data words are latched onto the fpu_* buses.
  - If the opcode is illegal: go to DONE with res_illegal=1, res_valid at N+1, and fpu_execute is never asserted.
  - Otherwise: go to ISSUE.
- ISSUE (cycle N+1): fpu_execute=1 for exactly this cycle; go to GUARD.
- GUARD: stay for READY_GUARD cycles with fpu_ready ignored, then go to WAIT.
- WAIT: the counter increments each cycle.
  - fpu_ready=1: latch fpu_error. If the instruction is a store, latch fpu_data_out and fpu_int_data_out. Go to DONE.
  - Counter reaches TIMEOUT_CYCLES with ready low: res_timeout=1, res_data=0, go to DONE.
  - Ready and timeout in the same cycle: ready wins.
- DONE: res_valid=1 for one cycle with the res_* fields valid; return to IDLE.
  - res_* fields hold their values until the next res_valid.
  - esc_ready reasserts the cycle after res_valid, so back-to-back instructions see at most one new acceptance per completion.
- fpu_opcode, fpu_modrm, fpu_data_in and fpu_int_data_in stay stable from ISSUE through DONE.
- Store classification (res_store), valid only with mod != 2'b11 (reg = modrm[5:3]):
  - D9 reg 2/3 (FST/FSTP m32)
  - DD reg 2/3 (m64)
  - DB reg 2/3/7 (FIST m32, FSTP m80)
  - DF reg 2/3/7 (FIST m16, FISTP m64)
  - All other legal opcodes are non-store.
- No back-pressure on res_valid: the CPU must consume the pulse.
- Counter width is $clog2(TIMEOUT_CYCLES+1). The counter clears on entry to WAIT.

Test Plan:
1. FLD1 (D9/E8) accepted at N, fpu_ready low N+1..N+5 then high at N+6 → fpu_execute high only at N+1; res_valid at N+7; res_store=0, res_data=0, res_error=0.
2. FSTP m80 (DB/3B) with fpu_data_out=3FFF8000000000000000 at ready → res_store=1, res_data=3FFF8000000000000000.
3. esc_opcode=90 → res_valid with res_illegal=1 at N+1; fpu_execute never asserted; fpu_busy high one cycle.
4. TIMEOUT_CYCLES=16 with fpu_ready held low → res_timeout=1 after 16 WAIT cycles; esc_ready returns the following cycle.
5. fpu_ready held high throughout, FCHS (D9/E0) → ready ignored during GUARD; res_valid at N+4 (READY_GUARD=1); fpu_error=1 at ready gives res_error=1.
6. Reset asserted mid-WAIT → all outputs 0 asynchronously, esc_ready=1 after release, no res_valid. A subsequent FLDZ (D9/EE) completes normally.
